// File: rtl/hpb_wr_ctrl.sv
// Host programming bridge: gathers 32-bit host writes into one RCB-wide shadow
// entry, then issues it to the RCB write port with a req/done handshake and timeout.
module hpb_wr_ctrl #(
    parameter int RAM_WIDTH  = 128,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 255,
    localparam int N_WORDS   = RAM_WIDTH / 32,
    localparam int IDX_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  host_wr_valid,
    output logic                  host_wr_ready,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [IDX_W-1:0]      host_wr_word,
    input  logic [31:0]           host_wr_data,
    input  logic                  host_wr_last,
    output logic [ADDR_WIDTH-1:0] hpb_wr_addr,
    output logic [RAM_WIDTH-1:0]  hpb_wr_data,
    output logic                  hpb_wr_en,
    output logic                  hpb_wr_req,
    input  logic                  rcb_wr_done,
    input  logic                  hpb_err_clr,
    output logic                  hpb_busy,
    output logic                  hpb_err_timeout,
    output logic                  hpb_err_range,
    output logic [15:0]           hpb_wr_count
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2
    } state_e;

    localparam logic [31:0] N_WORDS_L = 32'(N_WORDS);
    // The final WAIT cycle is the TIMEOUT-th one, since the counter starts at 0.
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [RAM_WIDTH-1:0]    shadow_q, shadow_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             tcnt_q, tcnt_d;
    logic [15:0]             count_q, count_d;
    logic                    busy_q, busy_d;
    logic                    err_tmo_q, err_tmo_d;
    logic                    err_rng_q, err_rng_d;
    logic                    ready_q, ready_d;
    logic                    req_q, req_d;
    logic                    en_q, en_d;
    logic                    word_ok_s;
    logic                    range_set_s;
    logic                    tmo_set_s;

    // Next-state, shadow update, counters and sticky error logic.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        addr_d      = addr_q;
        tcnt_d      = tcnt_q;
        count_d     = count_q;
        busy_d      = busy_q;
        range_set_s = 1'b0;
        tmo_set_s   = 1'b0;
        word_ok_s   = (32'(host_wr_word) < N_WORDS_L);

        case (state_q)
            ST_COLLECT: begin
                if (host_wr_valid) begin
                    busy_d = 1'b1;
                    if (word_ok_s) begin
                        for (int k = 0; k < N_WORDS; k++) begin
                            if (host_wr_word == IDX_W'(k)) begin
                                shadow_d[32*k +: 32] = host_wr_data;
                            end else begin
                                shadow_d[32*k +: 32] = shadow_q[32*k +: 32];
                            end
                        end
                    end else begin
                        range_set_s = 1'b1;
                    end
                    if (host_wr_last) begin
                        addr_d  = host_wr_addr;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_ISSUE: begin
                tcnt_d  = 16'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                tcnt_d = tcnt_q + 16'd1;
                // Done takes priority over a coincident timeout.
                if (rcb_wr_done) begin
                    state_d  = ST_COLLECT;
                    count_d  = count_q + 16'd1;
                    shadow_d = {RAM_WIDTH{1'b0}};
                    busy_d   = 1'b0;
                end else if (tcnt_q == TMO_LAST) begin
                    state_d   = ST_COLLECT;
                    shadow_d  = {RAM_WIDTH{1'b0}};
                    busy_d    = 1'b0;
                    tmo_set_s = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d  = ST_COLLECT;
                shadow_d = {RAM_WIDTH{1'b0}};
                busy_d   = 1'b0;
            end
        endcase

        err_rng_d = range_set_s | (err_rng_q & ~hpb_err_clr);
        err_tmo_d = tmo_set_s   | (err_tmo_q & ~hpb_err_clr);
        ready_d   = (state_d == ST_COLLECT);
        req_d     = (state_d != ST_COLLECT);
        en_d      = (state_d == ST_ISSUE);
    end

    // State and output registers; reset drops req/en/busy immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_COLLECT;
            shadow_q  <= {RAM_WIDTH{1'b0}};
            addr_q    <= {ADDR_WIDTH{1'b0}};
            tcnt_q    <= 16'd0;
            count_q   <= 16'd0;
            busy_q    <= 1'b0;
            err_tmo_q <= 1'b0;
            err_rng_q <= 1'b0;
            ready_q   <= 1'b1;
            req_q     <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            addr_q    <= addr_d;
            tcnt_q    <= tcnt_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            err_tmo_q <= err_tmo_d;
            err_rng_q <= err_rng_d;
            ready_q   <= ready_d;
            req_q     <= req_d;
            en_q      <= en_d;
        end
    end

    assign host_wr_ready   = ready_q;
    assign hpb_wr_addr     = addr_q;
    assign hpb_wr_data     = shadow_q;
    assign hpb_wr_en       = en_q;
    assign hpb_wr_req      = req_q;
    assign hpb_busy        = busy_q;
    assign hpb_err_timeout = err_tmo_q;
    assign hpb_err_range   = err_rng_q;
    assign hpb_wr_count    = count_q;

endmodule

// File: tb/tb_hpb_wr_ctrl.sv
// Directed bench for hpb_wr_ctrl: a 128-bit instance (TIMEOUT=8) and a 96-bit
// instance used for out-of-range word indices.
module tb_hpb_wr_ctrl;

    logic         clk;
    logic         reset_n;
    logic         valid_a, valid_b;
    logic         last;
    logic [9:0]   addr;
    logic [1:0]   word;
    logic [31:0]  data;
    logic         done_a, done_b;
    logic         err_clr;

    logic         a_ready, a_en, a_req, a_busy, a_err_t, a_err_r;
    logic [9:0]   a_addr;
    logic [127:0] a_data;
    logic [15:0]  a_count;

    logic         b_ready, b_en, b_req, b_busy, b_err_t, b_err_r;
    logic [9:0]   b_addr;
    logic [95:0]  b_data;
    logic [15:0]  b_count;

    int checks;
    int errors;
    int hi;

    hpb_wr_ctrl #(.RAM_WIDTH(128), .ADDR_WIDTH(10), .TIMEOUT(8)) u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .host_wr_valid(valid_a), .host_wr_ready(a_ready),
        .host_wr_addr(addr), .host_wr_word(word), .host_wr_data(data), .host_wr_last(last),
        .hpb_wr_addr(a_addr), .hpb_wr_data(a_data), .hpb_wr_en(a_en), .hpb_wr_req(a_req),
        .rcb_wr_done(done_a), .hpb_err_clr(err_clr), .hpb_busy(a_busy),
        .hpb_err_timeout(a_err_t), .hpb_err_range(a_err_r), .hpb_wr_count(a_count)
    );

    hpb_wr_ctrl #(.RAM_WIDTH(96), .ADDR_WIDTH(10), .TIMEOUT(8)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .host_wr_valid(valid_b), .host_wr_ready(b_ready),
        .host_wr_addr(addr), .host_wr_word(word), .host_wr_data(data), .host_wr_last(last),
        .hpb_wr_addr(b_addr), .hpb_wr_data(b_data), .hpb_wr_en(b_en), .hpb_wr_req(b_req),
        .rcb_wr_done(done_b), .hpb_err_clr(err_clr), .hpb_busy(b_busy),
        .hpb_err_timeout(b_err_t), .hpb_err_range(b_err_r), .hpb_wr_count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit sel_b, input logic [1:0] w, input logic [31:0] d,
                        input logic l, input logic [9:0] a);
        word = w;
        data = d;
        last = l;
        addr = a;
        if (sel_b) valid_b = 1'b1;
        else       valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        valid_b = 1'b0;
        last    = 1'b0;
    endtask

    task automatic pulse_done(input bit sel_b);
        if (sel_b) done_b = 1'b1;
        else       done_a = 1'b1;
        tick();
        done_a = 1'b0;
        done_b = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        last    = 1'b0;
        addr    = 10'd0;
        word    = 2'd0;
        data    = 32'd0;
        done_a  = 1'b0;
        done_b  = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check_val("rst_ready", a_ready, 1'b1);
        check_val("rst_req",   a_req,   1'b0);
        check_val("rst_en",    a_en,    1'b0);
        check_val("rst_busy",  a_busy,  1'b0);
        check_val("rst_count", a_count, 16'd0);
        check_val("rst_data",  a_data,  128'd0);
        check_val("rst_errs",  {a_err_t, a_err_r}, 2'b00);
        reset_n = 1'b1;
        tick();

        // Full four-word entry
        beat(1'b0, 2'd0, 32'h11111111, 1'b0, 10'h000);
        check_val("busy_first", a_busy, 1'b1);
        beat(1'b0, 2'd1, 32'h22222222, 1'b0, 10'h000);
        beat(1'b0, 2'd2, 32'h33333333, 1'b0, 10'h000);
        beat(1'b0, 2'd3, 32'h44444444, 1'b1, 10'h005);
        check_val("t1_en",    a_en,   1'b1);
        check_val("t1_data",  a_data, 128'h44444444_33333333_22222222_11111111);
        check_val("t1_addr",  a_addr, 10'h005);
        check_val("t1_ready", a_ready, 1'b0);
        tick();
        check_val("t1_en_off", a_en,  1'b0);
        check_val("t1_req",    a_req, 1'b1);
        tick();
        pulse_done(1'b0);
        check_val("t1_req_off", a_req,   1'b0);
        check_val("t1_count",   a_count, 16'd1);
        check_val("t1_busy",    a_busy,  1'b0);
        check_val("t1_ready_b", a_ready, 1'b1);

        // Partial entry, then minimum-turnaround entry after shadow clear
        beat(1'b0, 2'd2, 32'hDEADBEEF, 1'b1, 10'h3FF);
        check_val("t2_data", a_data, 128'h00000000_DEADBEEF_00000000_00000000);
        check_val("t2_addr", a_addr, 10'h3FF);
        tick();
        pulse_done(1'b0);
        check_val("t2_gap_req", a_req, 1'b0);
        beat(1'b0, 2'd0, 32'h00000001, 1'b1, 10'h010);
        check_val("t2_turn_en", a_en,   1'b1);
        check_val("t2_data2",   a_data, 128'h1);
        tick();
        pulse_done(1'b0);
        check_val("t2_count", a_count, 16'd3);

        // Timeout: ISSUE + 8 WAIT cycles of req
        beat(1'b0, 2'd1, 32'h0000AAAA, 1'b1, 10'h007);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_req) hi++;
            tick();
        end
        check_val("t3_req_cycles", hi, 9);
        check_val("t3_err_tmo",    a_err_t, 1'b1);
        check_val("t3_count",      a_count, 16'd3);
        check_val("t3_ready",      a_ready, 1'b1);
        check_val("t3_busy",       a_busy,  1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_val("t3_err_clr", a_err_t, 1'b0);

        // Range error on 96-bit instance; clear in same cycle as set
        beat(1'b1, 2'd0, 32'hCAFE0000, 1'b0, 10'h000);
        check_val("t4_err_pre", b_err_r, 1'b0);
        err_clr = 1'b1;
        beat(1'b1, 2'd3, 32'h00000BAD, 1'b0, 10'h000);
        err_clr = 1'b0;
        check_val("t4_err_rng", b_err_r, 1'b1);
        check_val("t4_ready",   b_ready, 1'b1);
        beat(1'b1, 2'd1, 32'h12345678, 1'b1, 10'h022);
        check_val("t4_data", b_data, 96'h00000000_12345678_CAFE0000);
        check_val("t4_en",   b_en,   1'b1);
        tick();
        pulse_done(1'b1);
        check_val("t4_count", b_count, 16'd1);
        check_val("t4_a_rng", a_err_r, 1'b0);

        // Back-pressure: beat held during ISSUE/WAIT is taken only in COLLECT
        beat(1'b0, 2'd0, 32'h00000055, 1'b1, 10'h009);
        check_val("t5_data1", a_data, 128'h55);
        word    = 2'd1;
        data    = 32'h00000066;
        last    = 1'b1;
        addr    = 10'h00A;
        valid_a = 1'b1;
        tick();
        check_val("t5_ready_wait", a_ready, 1'b0);
        pulse_done(1'b0);
        check_val("t5_count", a_count, 16'd4);
        tick();
        valid_a = 1'b0;
        last    = 1'b0;
        check_val("t5_data2", a_data, 128'h00000000_00000000_00000066_00000000);
        check_val("t5_addr2", a_addr, 10'h00A);
        // Done lands on the timeout cycle
        repeat (8) tick();
        pulse_done(1'b0);
        check_val("t5_coinc_err",   a_err_t, 1'b0);
        check_val("t5_coinc_count", a_count, 16'd5);
        check_val("t5_coinc_req",   a_req,   1'b0);
        // Stray done in COLLECT
        pulse_done(1'b0);
        check_val("t5_stray_count", a_count, 16'd5);
        check_val("t5_stray_ready", a_ready, 1'b1);

        // Async reset in WAIT
        beat(1'b0, 2'd3, 32'h00000077, 1'b1, 10'h001);
        tick();
        check_val("t6_req_wait", a_req, 1'b1);
        reset_n = 1'b0;
        #2;
        check_val("t6_rst_req",  a_req,  1'b0);
        check_val("t6_rst_en",   a_en,   1'b0);
        check_val("t6_rst_busy", a_busy, 1'b0);
        #1;
        reset_n = 1'b1;
        tick();
        check_val("t6_count0", a_count, 16'd0);
        beat(1'b0, 2'd0, 32'h00000099, 1'b1, 10'h002);
        check_val("t6_en",   a_en,   1'b1);
        check_val("t6_data", a_data, 128'h99);
        check_val("t6_addr", a_addr, 10'h002);
        tick();
        pulse_done(1'b0);
        check_val("t6_count1", a_count, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
